// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one imem request at a time,
// holds the fetched word for decode and applies trap/branch redirects.
module fetch_ctrl #(
   parameter int unsigned   AW       = 32,
   parameter int unsigned   DW       = 32,
   parameter logic [AW-1:0] RST_ADDR = 32'h0000_0000,
   parameter logic [DW-1:0] NOP      = 32'h0000_0013
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          fetch_en,
   input  logic          trap_valid,
   input  logic [AW-1:0] trap_pc,
   input  logic          redirect_valid,
   input  logic [AW-1:0] redirect_pc,
   output logic          imem_req_valid,
   input  logic          imem_req_ready,
   output logic [AW-1:0] imem_req_addr,
   input  logic          imem_rsp_valid,
   input  logic [DW-1:0] imem_rsp_data,
   output logic          if_valid,
   input  logic          if_ready,
   output logic [DW-1:0] if_instr,
   output logic [AW-1:0] if_pc,
   output logic          if_misalign,
   output logic [AW-1:0] pc
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      HOLD
   } state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   pc_q, pc_d;
   logic            kill_q, kill_d;
   logic            req_valid_q, req_valid_d;
   logic            if_valid_q, if_valid_d;
   logic [DW-1:0]   if_instr_q, if_instr_d;
   logic [AW-1:0]   if_pc_q, if_pc_d;
   logic            if_misalign_q, if_misalign_d;

   logic            redir;
   logic [AW-1:0]   tgt;
   logic            misal;
   state_e          go_st;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      kill_d        = kill_q;
      if_instr_d    = if_instr_q;
      if_pc_d       = if_pc_q;
      if_misalign_d = if_misalign_q;

      redir = trap_valid | redirect_valid;
      tgt   = trap_valid ? trap_pc : redirect_pc;
      misal = |pc_q[1:0];
      go_st = fetch_en ? REQ : IDLE;

      unique case (state_q)
         IDLE: begin
            if (redir) pc_d = tgt;
            if (fetch_en) state_d = REQ;
         end
         REQ: begin
            if (redir) begin
               pc_d = tgt;
               // an accepted request to the old address is stale
               if (!misal && imem_req_ready) begin
                  state_d = WAIT;
                  kill_d  = 1'b1;
               end
            end else if (misal) begin
               if_instr_d    = NOP;
               if_pc_d       = pc_q;
               if_misalign_d = 1'b1;
               state_d       = HOLD;
            end else if (imem_req_ready) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (imem_rsp_valid) begin
               if (kill_q || redir) begin
                  kill_d = 1'b0;
                  if (redir) pc_d = tgt;
                  state_d = go_st;
               end else begin
                  if_instr_d    = imem_rsp_data;
                  if_pc_d       = pc_q;
                  if_misalign_d = 1'b0;
                  state_d       = HOLD;
               end
            end else if (redir) begin
               pc_d   = tgt;
               kill_d = 1'b1;
            end
         end
         HOLD: begin
            if (redir) begin
               pc_d    = tgt;
               state_d = go_st;
            end else if (if_ready) begin
               pc_d    = pc_q + AW'(4);
               state_d = go_st;
            end
         end
         default: state_d = IDLE;
      endcase

      req_valid_d = (state_d == REQ) && (pc_d[1:0] == 2'b00);
      if_valid_d  = (state_d == HOLD);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         pc_q          <= RST_ADDR;
         kill_q        <= 1'b0;
         req_valid_q   <= 1'b0;
         if_valid_q    <= 1'b0;
         if_instr_q    <= NOP;
         if_pc_q       <= RST_ADDR;
         if_misalign_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         kill_q        <= kill_d;
         req_valid_q   <= req_valid_d;
         if_valid_q    <= if_valid_d;
         if_instr_q    <= if_instr_d;
         if_pc_q       <= if_pc_d;
         if_misalign_q <= if_misalign_d;
      end
   end

   assign imem_req_valid = req_valid_q;
   assign imem_req_addr  = pc_q;
   assign pc             = pc_q;
   assign if_valid       = if_valid_q;
   assign if_instr       = if_instr_q;
   assign if_pc          = if_pc_q;
   assign if_misalign    = if_misalign_q;

endmodule
